// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request/quiesce handshake and staged reset outputs of the reset sequencer.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              req;
    logic              quiesce_ack;
    logic              quiesce_req;
    logic [STAGES-1:0] stage_rst;
    logic              done;
    logic              timed_out;
    modport master (input req, quiesce_ack, output quiesce_req, stage_rst, done, timed_out);
    modport slave  (output req, quiesce_ack, input quiesce_req, stage_rst, done, timed_out);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of per-subsystem resets with quiesced run-time resets.
// Define RSTSEQ_TIMEOUT_EN to force the reset when quiesce_ack does not arrive in time.
module reset_sequencer #(
    parameter int STAGES      = 3,
    parameter int HOLD        = 8,
    parameter int STAGE_DELAY = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    reset_sequencer_if.master bus
);
    localparam int MAX_HD = (HOLD > STAGE_DELAY) ? HOLD : STAGE_DELAY;
    localparam int MAXC   = (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
    localparam logic [CW-1:0] DLY_END  = CW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(STAGES - 1);
    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_QUIESCE} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [STAGES-1:0] r_stage_rst;
    logic              r_quiesce_req;
    logic              r_done;
    logic              w_timeout;
`ifdef RSTSEQ_TIMEOUT_EN
    localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);
    logic r_timed_out;
    assign w_timeout     = r_cnt == ACK_END;
    assign bus.timed_out = r_timed_out;
`else
    assign w_timeout     = 1'b0;
    assign bus.timed_out = 1'b0;
`endif
    assign bus.stage_rst   = r_stage_rst;
    assign bus.quiesce_req = r_quiesce_req;
    assign bus.done        = r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_HOLD;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst   <= '1;
            r_quiesce_req <= 1'b0;
            r_done        <= 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
            r_timed_out   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_END) begin
                        r_stage_rst[0] <= 1'b0;
                        r_cnt          <= '0;
                        r_idx          <= IW'(1);
                        r_state        <= (STAGES == 1) ? S_RUN : S_RELEASE;
                        r_done         <= STAGES == 1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == DLY_END) begin
                        r_stage_rst[r_idx] <= 1'b0;
                        r_cnt              <= '0;
                        r_idx              <= r_idx + 1'b1;
                        r_state            <= (r_idx == LAST_IDX) ? S_RUN : S_RELEASE;
                        r_done             <= r_idx == LAST_IDX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.req) begin
                        r_quiesce_req <= 1'b1;
                        r_done        <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_QUIESCE;
                    end
                end
                default: begin
                    // An ack on the timeout edge wins, so timed_out only records genuine forced resets
                    if (bus.quiesce_ack || w_timeout) begin
                        r_stage_rst   <= '1;
                        r_quiesce_req <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_HOLD;
`ifdef RSTSEQ_TIMEOUT_EN
                        r_timed_out   <= r_timed_out | ~bus.quiesce_ack;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a timestamp-based model.
module tb_reset_sequencer;
    localparam int STAGES = 3, HOLD = 8, DLY = 4, ACK_TIMEOUT = 16;
    localparam int LAST = HOLD + (STAGES - 1) * DLY;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    reset_sequencer_if #(.STAGES(STAGES)) bus ();
    reset_sequencer #(.STAGES(STAGES), .HOLD(HOLD), .STAGE_DELAY(DLY), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0, failures = 0;
    int m_edge = 0, m_e0 = 0, m_qstart = 0;
    bit m_q = 0, m_to = 0;
    logic [STAGES+2:0] obs;
    assign obs = {bus.stage_rst, bus.done, bus.quiesce_req, bus.timed_out};
    // Expected outputs follow from edges elapsed since the last all-stage assertion
    function automatic logic [STAGES+2:0] model_out();
        logic [STAGES-1:0] s;
        int n;
        n = m_edge - m_e0;
        for (int k = 0; k < STAGES; k++) s[k] = !m_q && (n < HOLD + k * DLY);
        return {s, !m_q && (n >= LAST), m_q, m_to};
    endfunction
    task automatic tick(input logic r, input logic q, input logic a);
        bit running;
        rst = r;
        bus.req = q;
        bus.quiesce_ack = a;
        @(posedge clk);
        running = !m_q && (m_edge - m_e0 >= LAST);
        m_edge++;
        if (r) begin
            m_e0 = m_edge; m_q = 0; m_to = 0;
        end else if (m_q) begin
            if (a) begin
                m_q = 0; m_e0 = m_edge;
`ifdef RSTSEQ_TIMEOUT_EN
            end else if (m_edge - m_qstart == ACK_TIMEOUT) begin
                m_q = 0; m_e0 = m_edge; m_to = 1;
`endif
            end
        end else if (running && q) begin
            m_q = 1; m_qstart = m_edge;
        end
        #1;
    endtask
    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        checks++;
        if (obs !== {3'b111, 3'b000}) begin failures++; $display("FAIL reset_state got=%b want=%b", obs, 6'b111000); end
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs !== model_out()) begin failures++; $display("FAIL power_on edge=%0d got=%b want=%b", i, obs, model_out()); end
            if (i == 8 || i == 12 || i == 16) begin
                checks++;
                if (bus.stage_rst !== ((i == 8) ? 3'b110 : (i == 12) ? 3'b100 : 3'b000) || bus.done !== (i == 16)) begin
                    failures++; $display("FAIL power_on_release edge=%0d got=%b done=%b", i, bus.stage_rst, bus.done);
                end
            end
        end
    endtask
    task automatic test_request();
        tick(0, 1, 0);
        checks++;
        if (bus.quiesce_req !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL req_latency got qreq=%b done=%b want 1 0", bus.quiesce_req, bus.done); end
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        checks++;
        if (obs !== {3'b111, 3'b000}) begin failures++; $display("FAIL ack_assert got=%b want=%b", obs, 6'b111000); end
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs !== model_out()) begin failures++; $display("FAIL req_rerelease edge=%0d got=%b want=%b", i, obs, model_out()); end
        end
        checks++;
        if (obs !== 6'b000100) begin failures++; $display("FAIL req_done got=%b want=%b", obs, 6'b000100); end
    endtask
`ifdef RSTSEQ_TIMEOUT_EN
    task automatic test_timeout();
        tick(0, 1, 0);
        for (int i = 1; i <= 15; i++) tick(0, 0, 0);
        checks++;
        if (obs !== 6'b000010) begin failures++; $display("FAIL timeout_wait got=%b want=%b", obs, 6'b000010); end
        tick(0, 0, 0);
        checks++;
        if (obs !== 6'b111001) begin failures++; $display("FAIL timeout_fire got=%b want=%b", obs, 6'b111001); end
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs !== model_out() || bus.timed_out !== 1'b1) begin failures++; $display("FAIL timeout_sticky edge=%0d got=%b want=%b", i, obs, model_out()); end
        end
        tick(1, 0, 0);
        checks++;
        if (bus.timed_out !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b want=0", bus.timed_out); end
        for (int i = 0; i < 16; i++) tick(0, 0, 0);
        tick(0, 1, 0);
        for (int i = 1; i <= 15; i++) tick(0, 0, 0);
        tick(0, 0, 1);
        checks++;
        if (obs !== 6'b111000) begin failures++; $display("FAIL ack_timeout_same_edge got=%b want=%b", obs, 6'b111000); end
        for (int i = 0; i < 16; i++) tick(0, 0, 0);
    endtask
`else
    task automatic test_no_timeout();
        tick(0, 1, 0);
        for (int i = 1; i <= 200; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs !== model_out()) begin failures++; $display("FAIL no_timeout edge=%0d got=%b want=%b", i, obs, model_out()); end
        end
        checks++;
        if (obs !== 6'b000010) begin failures++; $display("FAIL no_timeout_hold got=%b want=%b", obs, 6'b000010); end
        tick(0, 0, 1);
        checks++;
        if (obs !== 6'b111000) begin failures++; $display("FAIL late_ack got=%b want=%b", obs, 6'b111000); end
        for (int i = 0; i < 16; i++) tick(0, 0, 0);
        checks++;
        if (obs !== 6'b000100) begin failures++; $display("FAIL late_ack_done got=%b want=%b", obs, 6'b000100); end
    endtask
`endif
    task automatic test_rst_mid_release();
        tick(1, 0, 0);
        for (int i = 1; i <= 9; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        checks++;
        if (bus.stage_rst !== 3'b111) begin failures++; $display("FAIL mid_release_assert got=%b want=111", bus.stage_rst); end
        for (int i = 1; i <= 8; i++) tick(0, 0, 0);
        checks++;
        if (bus.stage_rst !== 3'b110) begin failures++; $display("FAIL mid_release_restart got=%b want=110", bus.stage_rst); end
        for (int i = 0; i < 8; i++) tick(0, 0, 0);
    endtask
    task automatic test_req_during_hold();
        tick(1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            tick(0, 1, 0);
            checks++;
            if (obs !== model_out()) begin failures++; $display("FAIL req_in_hold edge=%0d got=%b want=%b", i, obs, model_out()); end
        end
        checks++;
        if (obs !== 6'b000100) begin failures++; $display("FAIL req_in_hold_done got=%b want=%b", obs, 6'b000100); end
        tick(0, 0, 0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
            checks++;
            if (obs !== model_out()) begin failures++; $display("FAIL random cycle=%0d got=%b want=%b", i, obs, model_out()); end
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.req = 1'b0;
        bus.quiesce_ack = 1'b0;
        test_reset();
        test_request();
`ifdef RSTSEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_rst_mid_release();
        test_req_during_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
